awmc_actuator_drv: RTL and testbench
====================================

Name: awmc_actuator_drv

Overview:
- Downstream of the washing-machine controller FSM.
- Consumes its stage code, done pulse, pause and lid inputs, and drives the physical actuators: fill valve, drain pump, drum motor (enable/direction/speed), door lock and end-of-cycle buzzer.
- Owns motor agitation timing, spin ramp, brake-down and door-unlock safety interlock, so the controller deals only in stages.

Parameters:
- SPEED_W, 4, width of motor_speed.
- SPIN_MAX, 15, spin target speed (must be < 2**SPEED_W).
- AGITATE_CYC, 8, cycles per agitation stroke.
- DWELL_CYC, 2, motor-off cycles between stroke reversals.
- RAMP_CYC, 2, cycles per +/-1 speed step.
- UNLOCK_CYC, 4, cycles after motor_speed reaches 0 before door_lock releases.
- BUZZ_CYC, 6, buzzer duration in cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- stage  in  3  controller stage: 0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 DRAIN, 5 SPIN; 6,7 treated as IDLE.
- done  in  1  cycle-complete pulse from controller.
- pause  in  1  1 = paused.
- lid  in  1  1 = lid closed.
- fill_valve  out  1  water inlet valve.
- drain_pump  out  1  drain pump.
- motor_en  out  1  drum motor enable.
- motor_dir  out  1  0 = forward, 1 = reverse.
- motor_speed  out  SPEED_W  drum speed command.
- door_lock  out  1  1 = door locked.
- buzzer  out  1  end-of-cycle buzzer.
- fault  out  1  lid opened while active.

Behaviour:
- All outputs registered; response appears the cycle after the input sample.
- Reset (reset=0 at a clock edge):
  - all outputs 0;
  - motor FSM to M_IDLE;
  - counters cleared.
- Reset mid-operation forces immediate stop, ignoring ramps and unlock delay.
- active = (stage in 1..5) && !pause && lid.
- fill_valve = active && stage==FILL.
- drain_pump = active && (stage==DRAIN || stage==SPIN).
- Motor FSM states:
  - M_IDLE: speed 0, motor_en 0.
  - M_FWD / M_REV: motor_en 1, speed 1, dir 0/1 respectively.
  - M_DWELL_F / M_DWELL_R: motor_en 0, speed 0.
  - M_SPIN: dir 0, ramp up to SPIN_MAX.
  - M_BRAKE: ramp down to 0.
- Transitions:
  - M_IDLE → M_FWD when active && stage in {WASH, RINSE}.
  - M_FWD → M_DWELL_F after AGITATE_CYC cycles → M_REV after DWELL_CYC → M_DWELL_R after AGITATE_CYC → M_FWD after DWELL_CYC, repeating.
  - M_IDLE → M_SPIN when active && stage==SPIN.
  - M_SPIN: speed +1 every RAMP_CYC cycles, saturating at SPIN_MAX.
  - Agitation states → M_IDLE immediately when not active, or when stage leaves WASH/RINSE.
  - M_SPIN → M_BRAKE when not active or stage!=SPIN.
  - M_BRAKE: speed -1 every RAMP_CYC cycles; → M_IDLE when speed==0.
  - WASH→RINSE directly: agitation restarts at M_FWD with counter cleared.
- door_lock:
  - set when active;
  - stays 1 while motor_speed!=0 or FSM in M_SPIN/M_BRAKE;
  - clears UNLOCK_CYC cycles after motor_speed==0 and not active;
  - unlock counter restarts if active reasserts.
  - Pause therefore unlocks only after brake + UNLOCK_CYC.
- fault:
  - set when lid==0 && stage in 1..5 && !pause;
  - forces valve/pump off and motor to M_BRAKE;
  - cleared when stage==IDLE or reset.
  - Lid opening while paused is not a fault.
- buzzer:
  - 1 for exactly BUZZ_CYC cycles starting the cycle after done==1.
  - A done arriving while buzzing restarts the count.
- Simultaneous pause and stage change: pause dominates; the new stage takes effect on resume.

Optional Feature:
- AWMC_SPIN_RAMP_EN defined: spin ramp-up and brake ramp-down as above.
- Undefined:
  - M_SPIN sets speed to SPIN_MAX on entry.
  - M_BRAKE holds speed at SPIN_MAX for RAMP_CYC*SPIN_MAX cycles, then drops to 0.
  - Unlock timing is otherwise unchanged.

Decomposition:
- Shared package awmc_pkg holds:
  - stage encodings (ST_IDLE..ST_SPIN);
  - motor state encodings;
  - default timing constants.
  The controller uses the same package.
- One sub-module, awmc_down_counter: loadable down-counter with zero flag. Instanced for the stroke/dwell timer, ramp timer, unlock timer and buzzer timer.

Test Plan:
- Reset low 2 cycles with stage=WASH, lid=1 → all outputs 0; after release, motor_en=1, dir=0 next cycle.
- stage=WASH, lid=1, pause=0 for 40 cycles → pattern FWD 8 / off 2 / REV 8 / off 2 repeating; door_lock=1 throughout.
- stage=SPIN 40 cycles then IDLE → speed climbs 1 per 2 cycles to 15 (reached 30 cycles in), drain_pump=1; after IDLE, speed falls to 0 in 30 cycles; door_lock drops 4 cycles later.
- SPIN at speed 15, pause=1 and lid=0 at once → no fault, pump off, brake to 0, unlock 4 cycles after 0.
- stage=FILL, lid 1→0 → fault=1, fill_valve=0 next cycle; stays until stage=IDLE.
- done pulse 1 cycle → buzzer=1 for 6 cycles; second done at buzz cycle 4 → buzzer 1 for 6 more cycles.

Source files
------------

// File: rtl/awmc_pkg.sv
// Shared encodings and default timing for the washing-machine controller and its actuator driver.
package awmc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_WASH  = 3'd2,
      ST_RINSE = 3'd3,
      ST_DRAIN = 3'd4,
      ST_SPIN  = 3'd5
   } stage_e;

   typedef enum logic [2:0] {
      M_IDLE,
      M_FWD,
      M_DWELL_F,
      M_REV,
      M_DWELL_R,
      M_SPIN,
      M_BRAKE
   } motor_state_e;

   localparam int DEF_SPEED_W     = 4;
   localparam int DEF_SPIN_MAX    = 15;
   localparam int DEF_AGITATE_CYC = 8;
   localparam int DEF_DWELL_CYC   = 2;
   localparam int DEF_RAMP_CYC    = 2;
   localparam int DEF_UNLOCK_CYC  = 4;
   localparam int DEF_BUZZ_CYC    = 6;

   // Wide enough for the longest timer load (non-ramped brake hold).
   localparam int CNT_W = 8;

   // Codes 6 and 7 are not run stages and behave like IDLE.
   function automatic logic is_run_stage(input logic [2:0] s);
      return (s >= 3'(ST_FILL)) && (s <= 3'(ST_SPIN));
   endfunction

endpackage

// File: rtl/awmc_down_counter.sv
// Loadable down-counter with zero flag; holds at zero, load wins over decrement.
module awmc_down_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/awmc_actuator_drv.sv
// Actuator driver: valve/pump/motor/door-lock/buzzer from controller stage.
// Define AWMC_SPIN_RAMP_EN for ramped spin-up and brake; otherwise spin is a step with a timed brake hold.
module awmc_actuator_drv
   import awmc_pkg::*;
#(
   parameter int SPEED_W     = DEF_SPEED_W,
   parameter int SPIN_MAX    = DEF_SPIN_MAX,
   parameter int AGITATE_CYC = DEF_AGITATE_CYC,
   parameter int DWELL_CYC   = DEF_DWELL_CYC,
   parameter int RAMP_CYC    = DEF_RAMP_CYC,
   parameter int UNLOCK_CYC  = DEF_UNLOCK_CYC,
   parameter int BUZZ_CYC    = DEF_BUZZ_CYC
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         stage,
   input  logic               done,
   input  logic               pause,
   input  logic               lid,
   output logic               fill_valve,
   output logic               drain_pump,
   output logic               motor_en,
   output logic               motor_dir,
   output logic [SPEED_W-1:0] motor_speed,
   output logic               door_lock,
   output logic               buzzer,
   output logic               fault
);

`ifdef AWMC_SPIN_RAMP_EN
   localparam bit RAMP_EN  = 1'b1;
   localparam int BRAKE_LV = RAMP_CYC - 1;
`else
   localparam bit RAMP_EN  = 1'b0;
   localparam int BRAKE_LV = RAMP_CYC * SPIN_MAX - 1;
`endif

   localparam logic [CNT_W-1:0] AGIT_LD   = CNT_W'(AGITATE_CYC - 1);
   localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYC - 1);
   localparam logic [CNT_W-1:0] STEP_LD   = CNT_W'(RAMP_CYC - 1);
   localparam logic [CNT_W-1:0] BRAKE_LD  = CNT_W'(BRAKE_LV);
   localparam logic [CNT_W-1:0] UNLOCK_LD = CNT_W'(UNLOCK_CYC - 1);
   localparam logic [CNT_W-1:0] BUZZ_LD   = CNT_W'(BUZZ_CYC - 1);
   localparam logic [SPEED_W-1:0] SPD_MAX = SPEED_W'(SPIN_MAX);
   localparam logic [SPEED_W-1:0] SPD_ONE = SPEED_W'(1);

   motor_state_e state;
   logic [2:0]   agit_stage;

   logic run_stage, fault_now, active, go_agit, go_spin, stage_chg, lock_hold;
   logic stroke_load, stroke_dec, stroke_zero;
   logic ramp_load, ramp_dec, ramp_zero;
   logic unlock_load, unlock_dec, unlock_zero;
   logic buzz_load, buzz_dec, buzz_zero;
   logic [CNT_W-1:0] stroke_val, ramp_val;

   // A latched fault keeps everything off even if the lid closes again.
   assign run_stage = is_run_stage(stage);
   assign fault_now = run_stage && !pause && !lid;
   assign active    = run_stage && !pause && lid && !fault;
   assign go_agit   = active && ((stage == ST_WASH) || (stage == ST_RINSE));
   assign go_spin   = active && (stage == ST_SPIN);
   assign stage_chg = (stage != agit_stage);
   assign lock_hold = (motor_speed != '0) || (state == M_SPIN) || (state == M_BRAKE);

   always_comb begin
      stroke_load = 1'b0;
      stroke_val  = '0;
      stroke_dec  = 1'b0;
      ramp_load   = 1'b0;
      ramp_val    = '0;
      ramp_dec    = 1'b0;
      case (state)
         M_IDLE: begin
            if (go_agit) begin
               stroke_load = 1'b1;
               stroke_val  = AGIT_LD;
            end else if (go_spin) begin
               ramp_load = 1'b1;
               ramp_val  = STEP_LD;
            end
         end
         M_FWD, M_REV: begin
            if (go_agit) begin
               if (stage_chg) begin
                  stroke_load = 1'b1;
                  stroke_val  = AGIT_LD;
               end else if (stroke_zero) begin
                  stroke_load = 1'b1;
                  stroke_val  = DWELL_LD;
               end else begin
                  stroke_dec = 1'b1;
               end
            end
         end
         M_DWELL_F, M_DWELL_R: begin
            if (go_agit) begin
               if (stage_chg || stroke_zero) begin
                  stroke_load = 1'b1;
                  stroke_val  = AGIT_LD;
               end else begin
                  stroke_dec = 1'b1;
               end
            end
         end
         M_SPIN: begin
            if (!go_spin) begin
               ramp_load = 1'b1;
               ramp_val  = BRAKE_LD;
            end else if (RAMP_EN) begin
               ramp_load = ramp_zero;
               ramp_val  = STEP_LD;
               ramp_dec  = !ramp_zero;
            end
         end
         M_BRAKE: begin
            if (RAMP_EN && ramp_zero) begin
               ramp_load = 1'b1;
               ramp_val  = STEP_LD;
            end else begin
               ramp_dec = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign unlock_load = active || (door_lock && lock_hold);
   assign unlock_dec  = !unlock_load;
   assign buzz_load   = done;
   assign buzz_dec    = !done;

   awmc_down_counter #(.W(CNT_W)) u_stroke (
      .clk(clk), .reset(reset), .load(stroke_load), .load_val(stroke_val),
      .dec(stroke_dec), .zero(stroke_zero));

   awmc_down_counter #(.W(CNT_W)) u_ramp (
      .clk(clk), .reset(reset), .load(ramp_load), .load_val(ramp_val),
      .dec(ramp_dec), .zero(ramp_zero));

   awmc_down_counter #(.W(CNT_W)) u_unlock (
      .clk(clk), .reset(reset), .load(unlock_load), .load_val(UNLOCK_LD),
      .dec(unlock_dec), .zero(unlock_zero));

   awmc_down_counter #(.W(CNT_W)) u_buzz (
      .clk(clk), .reset(reset), .load(buzz_load), .load_val(BUZZ_LD),
      .dec(buzz_dec), .zero(buzz_zero));

   // Motor FSM: outputs are registered alongside the state they belong to.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= M_IDLE;
         agit_stage  <= 3'd0;
         motor_en    <= 1'b0;
         motor_dir   <= 1'b0;
         motor_speed <= '0;
      end else begin
         case (state)
            M_IDLE: begin
               if (go_agit) begin
                  state       <= M_FWD;
                  agit_stage  <= stage;
                  motor_en    <= 1'b1;
                  motor_dir   <= 1'b0;
                  motor_speed <= SPD_ONE;
               end else if (go_spin) begin
                  state       <= M_SPIN;
                  motor_en    <= 1'b1;
                  motor_dir   <= 1'b0;
                  motor_speed <= RAMP_EN ? '0 : SPD_MAX;
               end else begin
                  motor_en    <= 1'b0;
                  motor_dir   <= 1'b0;
                  motor_speed <= '0;
               end
            end
            M_FWD, M_REV, M_DWELL_F, M_DWELL_R: begin
               if (!go_agit) begin
                  state       <= M_IDLE;
                  motor_en    <= 1'b0;
                  motor_dir   <= 1'b0;
                  motor_speed <= '0;
               end else if (stage_chg || (stroke_zero && (state == M_DWELL_R))) begin
                  state       <= M_FWD;
                  agit_stage  <= stage;
                  motor_en    <= 1'b1;
                  motor_dir   <= 1'b0;
                  motor_speed <= SPD_ONE;
               end else if (stroke_zero && (state == M_DWELL_F)) begin
                  state       <= M_REV;
                  motor_en    <= 1'b1;
                  motor_dir   <= 1'b1;
                  motor_speed <= SPD_ONE;
               end else if (stroke_zero) begin
                  state       <= (state == M_FWD) ? M_DWELL_F : M_DWELL_R;
                  motor_en    <= 1'b0;
                  motor_speed <= '0;
               end
            end
            M_SPIN: begin
               if (!go_spin) begin
                  if (motor_speed == '0) begin
                     state    <= M_IDLE;
                     motor_en <= 1'b0;
                  end else begin
                     state <= M_BRAKE;
                  end
               end else if (RAMP_EN && ramp_zero && (motor_speed < SPD_MAX)) begin
                  motor_speed <= motor_speed + SPD_ONE;
               end
            end
            M_BRAKE: begin
               if (ramp_zero) begin
                  if (!RAMP_EN || (motor_speed <= SPD_ONE)) begin
                     state       <= M_IDLE;
                     motor_en    <= 1'b0;
                     motor_speed <= '0;
                  end else begin
                     motor_speed <= motor_speed - SPD_ONE;
                  end
               end
            end
            default: begin
               state       <= M_IDLE;
               motor_en    <= 1'b0;
               motor_speed <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fill_valve <= 1'b0;
         drain_pump <= 1'b0;
         door_lock  <= 1'b0;
         buzzer     <= 1'b0;
         fault      <= 1'b0;
      end else begin
         fill_valve <= active && (stage == ST_FILL);
         drain_pump <= active && ((stage == ST_DRAIN) || (stage == ST_SPIN));
         if (!run_stage) begin
            fault <= 1'b0;
         end else if (fault_now) begin
            fault <= 1'b1;
         end
         if (active) begin
            door_lock <= 1'b1;
         end else if (!lock_hold && unlock_zero) begin
            door_lock <= 1'b0;
         end
         if (done) begin
            buzzer <= 1'b1;
         end else if (buzz_zero) begin
            buzzer <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_awmc_actuator_drv.sv
// Directed bench for awmc_actuator_drv; expectations follow AWMC_SPIN_RAMP_EN when it is defined.
module tb_awmc_actuator_drv;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FILL  = 3'd1;
   localparam logic [2:0] S_WASH  = 3'd2;
   localparam logic [2:0] S_RINSE = 3'd3;
   localparam logic [2:0] S_SPIN  = 3'd5;
`ifdef AWMC_SPIN_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] stage;
   logic       done, pause, lid;
   logic       fill_valve, drain_pump, motor_en, motor_dir, door_lock, buzzer, fault;
   logic [3:0] motor_speed;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   awmc_actuator_drv dut (
      .clk(clk), .reset(reset), .stage(stage), .done(done), .pause(pause), .lid(lid),
      .fill_valve(fill_valve), .drain_pump(drain_pump), .motor_en(motor_en),
      .motor_dir(motor_dir), .motor_speed(motor_speed), .door_lock(door_lock),
      .buzzer(buzzer), .fault(fault));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0; stage = S_IDLE; pause = 1'b0; lid = 1'b1; done = 1'b0;
      tick; tick;
      reset = 1'b1;
   endtask

   // Speed expected j cycles after brake entry from full spin speed.
   function automatic logic [3:0] brake_spd(input int j);
      if (j >= 30) return 4'd0;
      return RAMP ? 4'(15 - j / 2) : 4'd15;
   endfunction

   task automatic test_reset;
      reset = 1'b0; stage = S_WASH; lid = 1'b1; pause = 1'b0; done = 1'b0;
      tick; tick;
      n_checks++;
      if ({fill_valve, drain_pump, motor_en, motor_dir, door_lock, buzzer, fault} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 0000000",
                  {fill_valve, drain_pump, motor_en, motor_dir, door_lock, buzzer, fault});
      end
      n_checks++;
      if (motor_speed !== 4'd0) begin
         n_fail++; $display("FAIL reset_speed got %0d want 0", motor_speed);
      end
      reset = 1'b1;
      tick;
      n_checks++;
      if (motor_en !== 1'b1 || motor_dir !== 1'b0) begin
         n_fail++; $display("FAIL release_motor got en=%b dir=%b want en=1 dir=0", motor_en, motor_dir);
      end
      n_checks++;
      if (door_lock !== 1'b1) begin
         n_fail++; $display("FAIL release_lock got %b want 1", door_lock);
      end
   endtask

   task automatic test_wash;
      do_reset;
      stage = S_WASH;
      for (int k = 0; k < 40; k++) begin
         int  p;
         logic exp_en;
         tick;
         p = k % 20;
         exp_en = (p < 8) || (p >= 10 && p < 18);
         n_checks++;
         if (motor_en !== exp_en || motor_speed !== (exp_en ? 4'd1 : 4'd0)) begin
            n_fail++;
            $display("FAIL wash_en k=%0d got en=%b spd=%0d want en=%b", k, motor_en, motor_speed, exp_en);
         end
         n_checks++;
         if (exp_en && motor_dir !== (p >= 10)) begin
            n_fail++; $display("FAIL wash_dir k=%0d got %b want %b", k, motor_dir, (p >= 10));
         end
         n_checks++;
         if (door_lock !== 1'b1) begin
            n_fail++; $display("FAIL wash_lock k=%0d got %b want 1", k, door_lock);
         end
      end
      stage = S_IDLE;
      for (int j = 0; j < 5; j++) begin
         tick;
         n_checks++;
         if (motor_en !== 1'b0 || door_lock !== (j < 3)) begin
            n_fail++;
            $display("FAIL wash_stop j=%0d got en=%b lock=%b want en=0 lock=%b", j, motor_en, door_lock, (j < 3));
         end
      end
   endtask

   task automatic test_rinse_restart;
      do_reset;
      stage = S_WASH;
      for (int k = 0; k < 12; k++) tick;
      n_checks++;
      if (motor_en !== 1'b1 || motor_dir !== 1'b1) begin
         n_fail++; $display("FAIL pre_rinse_rev got en=%b dir=%b want en=1 dir=1", motor_en, motor_dir);
      end
      stage = S_RINSE;
      for (int j = 0; j < 9; j++) begin
         tick;
         n_checks++;
         if (motor_en !== (j < 8) || (j < 8 && motor_dir !== 1'b0)) begin
            n_fail++;
            $display("FAIL rinse_fwd j=%0d got en=%b dir=%b want en=%b dir=0", j, motor_en, motor_dir, (j < 8));
         end
      end
   endtask

   task automatic test_spin;
      do_reset;
      stage = S_SPIN;
      for (int k = 0; k < 40; k++) begin
         logic [3:0] exp_spd;
         tick;
         exp_spd = RAMP ? ((k / 2 > 15) ? 4'd15 : 4'(k / 2)) : 4'd15;
         n_checks++;
         if (motor_speed !== exp_spd || drain_pump !== 1'b1 || motor_en !== 1'b1) begin
            n_fail++;
            $display("FAIL spin_up k=%0d got spd=%0d pump=%b en=%b want spd=%0d pump=1 en=1",
                     k, motor_speed, drain_pump, motor_en, exp_spd);
         end
      end
      stage = S_IDLE;
      for (int j = 0; j < 36; j++) begin
         tick;
         n_checks++;
         if (motor_speed !== brake_spd(j) || door_lock !== (j < 34) || drain_pump !== 1'b0) begin
            n_fail++;
            $display("FAIL spin_brake j=%0d got spd=%0d lock=%b pump=%b want spd=%0d lock=%b pump=0",
                     j, motor_speed, door_lock, drain_pump, brake_spd(j), (j < 34));
         end
      end
   endtask

   task automatic test_pause_lid;
      do_reset;
      stage = S_SPIN;
      for (int k = 0; k < 32; k++) tick;
      n_checks++;
      if (motor_speed !== 4'd15) begin
         n_fail++; $display("FAIL pause_pre_speed got %0d want 15", motor_speed);
      end
      pause = 1'b1; lid = 1'b0;
      for (int j = 0; j < 36; j++) begin
         tick;
         n_checks++;
         if (fault !== 1'b0 || drain_pump !== 1'b0) begin
            n_fail++; $display("FAIL pause_nofault j=%0d got fault=%b pump=%b want 0 0", j, fault, drain_pump);
         end
         n_checks++;
         if (motor_speed !== brake_spd(j) || door_lock !== (j < 34)) begin
            n_fail++;
            $display("FAIL pause_brake j=%0d got spd=%0d lock=%b want spd=%0d lock=%b",
                     j, motor_speed, door_lock, brake_spd(j), (j < 34));
         end
      end
   endtask

   task automatic test_reset_mid;
      do_reset;
      stage = S_SPIN;
      for (int k = 0; k < 32; k++) tick;
      reset = 1'b0;
      tick;
      n_checks++;
      if (motor_speed !== 4'd0 || motor_en !== 1'b0 || door_lock !== 1'b0 || drain_pump !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid got spd=%0d en=%b lock=%b pump=%b want all 0",
                  motor_speed, motor_en, door_lock, drain_pump);
      end
      reset = 1'b1;
   endtask

   task automatic test_fault;
      do_reset;
      stage = S_FILL;
      tick;
      n_checks++;
      if (fill_valve !== 1'b1 || fault !== 1'b0) begin
         n_fail++; $display("FAIL fill_on got valve=%b fault=%b want 1 0", fill_valve, fault);
      end
      lid = 1'b0;
      tick;
      n_checks++;
      if (fault !== 1'b1 || fill_valve !== 1'b0) begin
         n_fail++; $display("FAIL fault_set got fault=%b valve=%b want 1 0", fault, fill_valve);
      end
      lid = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick;
         n_checks++;
         if (fault !== 1'b1 || fill_valve !== 1'b0) begin
            n_fail++; $display("FAIL fault_hold j=%0d got fault=%b valve=%b want 1 0", j, fault, fill_valve);
         end
      end
      stage = S_IDLE;
      tick;
      n_checks++;
      if (fault !== 1'b0) begin
         n_fail++; $display("FAIL fault_clear got %b want 0", fault);
      end
   endtask

   task automatic test_buzzer;
      do_reset;
      done = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick;
         done = 1'b0;
         n_checks++;
         if (buzzer !== (i <= 5)) begin
            n_fail++; $display("FAIL buzz_single i=%0d got %b want %b", i, buzzer, (i <= 5));
         end
      end
      done = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick;
         n_checks++;
         if (buzzer !== (i <= 9)) begin
            n_fail++; $display("FAIL buzz_restart i=%0d got %b want %b", i, buzzer, (i <= 9));
         end
         done = (i == 3);
      end
   endtask

   initial begin
      reset = 1'b0; stage = S_IDLE; done = 1'b0; pause = 1'b0; lid = 1'b1;
      test_reset;
      test_wash;
      test_rinse_restart;
      test_spin;
      test_pause_lid;
      test_reset_mid;
      test_fault;
      test_buzzer;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
